// File: rtl/pe_fxp_param.sv
// pe_fxp_param: weight-stationary fixed-point processing element for a systolic array.
//
// Computes psum_out = input * active_weight + psum_in in signed Qm.FRAC_BITS and
// forwards activation, valid, switch and weight-load signals one hop east/south.
// Weights are double-buffered: a background register loads while the foreground
// computes; a switch promotes the background weight to active.
//
// Build option:
//   PE_SATURATE_EN  defined   -> out-of-range results clamp, sticky overflow flag
//                   undefined -> results wrap to DATA_WIDTH bits, overflow tied to 0
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pe_psum_in        partial sum from north
//   pe_weight_in      weight from north
//   pe_accept_w_in    load pe_weight_in into the background weight register
//   pe_input_in       activation from west
//   pe_valid_in       input/psum valid this cycle
//   pe_switch_in      promote background weight to active
//   pe_psum_out       registered MAC result to south
//   pe_weight_out     registered weight forwarded south (0 when not loading)
//   pe_accept_w_out   registered pe_accept_w_in
//   pe_input_out      registered activation to east (holds when not valid)
//   pe_valid_out      registered pe_valid_in
//   pe_switch_out     registered pe_switch_in
//   pe_overflow_out   sticky overflow flag
module pe_fxp_param #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pe_psum_in,
   input  logic [DATA_WIDTH-1:0] pe_weight_in,
   input  logic                  pe_accept_w_in,
   input  logic [DATA_WIDTH-1:0] pe_input_in,
   input  logic                  pe_valid_in,
   input  logic                  pe_switch_in,
   output logic [DATA_WIDTH-1:0] pe_psum_out,
   output logic [DATA_WIDTH-1:0] pe_weight_out,
   output logic                  pe_accept_w_out,
   output logic [DATA_WIDTH-1:0] pe_input_out,
   output logic                  pe_valid_out,
   output logic                  pe_switch_out,
   output logic                  pe_overflow_out
);

   localparam int W = DATA_WIDTH;

   logic [W-1:0]   weight_active;
   logic [W-1:0]   weight_inactive;
   logic [W-1:0]   weight_eff;
   logic [2*W-1:0] input_ext;
   logic [2*W-1:0] weight_ext;
   logic [2*W-1:0] product;
   logic [2*W-1:0] scaled;
   logic [2*W:0]   sum;
   logic [W-1:0]   result;

   // A switch in the current cycle already uses the background weight.
   assign weight_eff = pe_switch_in ? weight_inactive : weight_active;

   // Sign-extend to 2W so an unsigned multiply yields the exact signed product.
   assign input_ext  = {{W{pe_input_in[W-1]}}, pe_input_in};
   assign weight_ext = {{W{weight_eff[W-1]}}, weight_eff};
   assign product    = input_ext * weight_ext;

   // Arithmetic shift truncates toward minus infinity.
   assign scaled = $signed(product) >>> FRAC_BITS;
   assign sum    = {scaled[2*W-1], scaled} + {{(W+1){pe_psum_in[W-1]}}, pe_psum_in};

`ifdef PE_SATURATE_EN
   logic ovf;
   logic overflow_q;

   // In range iff all bits from the sign position of a W-bit word upward agree.
   assign ovf = (sum[2*W:W-1] != '0) && (sum[2*W:W-1] != '1);

   always_comb begin
      result = sum[W-1:0];
      if (ovf) begin
         result = sum[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (pe_valid_in && ovf) begin
         overflow_q <= 1'b1;
      end
   end

   assign pe_overflow_out = overflow_q;
`else
   assign result          = W'(sum);
   assign pe_overflow_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weight_active   <= '0;
         weight_inactive <= '0;
         pe_weight_out   <= '0;
         pe_psum_out     <= '0;
         pe_input_out    <= '0;
         pe_valid_out    <= 1'b0;
         pe_switch_out   <= 1'b0;
         pe_accept_w_out <= 1'b0;
      end else begin
         if (pe_switch_in) begin
            weight_active <= weight_inactive;
         end
         if (pe_accept_w_in) begin
            weight_inactive <= pe_weight_in;
            pe_weight_out   <= pe_weight_in;
         end else begin
            pe_weight_out   <= '0;
         end
         if (pe_valid_in) begin
            pe_psum_out  <= result;
            pe_input_out <= pe_input_in;
         end else begin
            pe_psum_out  <= '0;
         end
         pe_valid_out    <= pe_valid_in;
         pe_switch_out   <= pe_switch_in;
         pe_accept_w_out <= pe_accept_w_in;
      end
   end

endmodule

// File: tb/tb_pe_fxp_param.sv
// Directed, table-driven bench for pe_fxp_param at default parameters (Q8.8).
// Expected values are hand-computed; both saturate and wrap expectations are
// stored and the one matching the PE_SATURATE_EN build is used.
module tb_pe_fxp_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pe_psum_in = '0;
   logic [15:0] pe_weight_in = '0;
   logic        pe_accept_w_in = 1'b0;
   logic [15:0] pe_input_in = '0;
   logic        pe_valid_in = 1'b0;
   logic        pe_switch_in = 1'b0;
   logic [15:0] pe_psum_out;
   logic [15:0] pe_weight_out;
   logic        pe_accept_w_out;
   logic [15:0] pe_input_out;
   logic        pe_valid_out;
   logic        pe_switch_out;
   logic        pe_overflow_out;

   int total = 0;
   int bad   = 0;

   pe_fxp_param #(
      .DATA_WIDTH(16),
      .FRAC_BITS (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pe_psum_in     (pe_psum_in),
      .pe_weight_in   (pe_weight_in),
      .pe_accept_w_in (pe_accept_w_in),
      .pe_input_in    (pe_input_in),
      .pe_valid_in    (pe_valid_in),
      .pe_switch_in   (pe_switch_in),
      .pe_psum_out    (pe_psum_out),
      .pe_weight_out  (pe_weight_out),
      .pe_accept_w_out(pe_accept_w_out),
      .pe_input_out   (pe_input_out),
      .pe_valid_out   (pe_valid_out),
      .pe_switch_out  (pe_switch_out),
      .pe_overflow_out(pe_overflow_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        accept;
      logic [15:0] weight;
      logic        sw;
      logic        valid;
      logic [15:0] in;
      logic [15:0] psum;
      logic [15:0] e_sat;
      logic [15:0] e_wrap;
      logic [15:0] e_in;
      logic [15:0] e_wout;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

`ifdef PE_SATURATE_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   function automatic vec_t mk(logic a, logic [15:0] w, logic s, logic v, logic [15:0] i,
                               logic [15:0] p, logic [15:0] es, logic [15:0] ew,
                               logic [15:0] ei, logic [15:0] ewo, logic eo);
      vec_t r;
      r.accept = a; r.weight = w; r.sw = s; r.valid = v; r.in = i; r.psum = p;
      r.e_sat = es; r.e_wrap = ew; r.e_in = ei; r.e_wout = ewo; r.e_ovf = eo;
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic a, input logic [15:0] w, input logic s, input logic v,
                        input logic [15:0] i, input logic [15:0] p);
      pe_accept_w_in = a;
      pe_weight_in   = w;
      pe_switch_in   = s;
      pe_valid_in    = v;
      pe_input_in    = i;
      pe_psum_in     = p;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " psum"},   pe_psum_out,     16'h0);
      chk({tag, " wout"},   pe_weight_out,   16'h0);
      chk({tag, " accept"}, {15'h0, pe_accept_w_out}, 16'h0);
      chk({tag, " input"},  pe_input_out,    16'h0);
      chk({tag, " valid"},  {15'h0, pe_valid_out},    16'h0);
      chk({tag, " switch"}, {15'h0, pe_switch_out},   16'h0);
      chk({tag, " ovf"},    {15'h0, pe_overflow_out}, 16'h0);
   endtask

   initial begin
      //           acc  weight  sw  vld  input    psum     sat      wrap     in_out   w_out   ovf
      vecs.push_back(mk(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0180, 16'h0100, 16'h0400, 16'h0400, 16'h0180, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0180, 16'h0000, 0));
      vecs.push_back(mk(1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0180, 16'h0100, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0180, 16'h0000, 0));
      vecs.push_back(mk(1, 16'h0300, 0, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0300, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 16'h0000, 16'h0300, 16'h0300, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 0));
      vecs.push_back(mk(1, 16'h0500, 1, 1, 16'h0100, 16'h0000, 16'h0200, 16'h0200, 16'h0100, 16'h0500, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 16'h0000, 16'h0200, 16'h0200, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0100, 16'h0000, 16'h0500, 16'h0500, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h7F00, 16'h0000, 16'h7FFF, 16'hFE00, 16'h7F00, 16'h0000, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 16'h0010, 16'h0210, 16'h0210, 16'h0100, 16'h0000, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'hFFFF, 16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h0100, 16'h7FFF, 16'h7FFF, 16'h81FF, 16'h0100, 16'h0000, 1));
      vecs.push_back(mk(1, 16'h0080, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0080, 1));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].accept, vecs[i].weight, vecs[i].sw, vecs[i].valid, vecs[i].in,
               vecs[i].psum);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d psum", i), pe_psum_out, Sat ? vecs[i].e_sat : vecs[i].e_wrap);
         chk($sformatf("v%0d input", i), pe_input_out, vecs[i].e_in);
         chk($sformatf("v%0d wout", i), pe_weight_out, vecs[i].e_wout);
         chk($sformatf("v%0d accept", i), {15'h0, pe_accept_w_out}, {15'h0, vecs[i].accept});
         chk($sformatf("v%0d valid", i), {15'h0, pe_valid_out}, {15'h0, vecs[i].valid});
         chk($sformatf("v%0d switch", i), {15'h0, pe_switch_out}, {15'h0, vecs[i].sw});
         chk($sformatf("v%0d ovf", i), {15'h0, pe_overflow_out},
             {15'h0, Sat ? vecs[i].e_ovf : 1'b0});
      end

      // Mid-cycle asynchronous reset with a load and switch pending
      drive(1'b1, 16'h0777, 1'b1, 1'b1, 16'h0300, 16'h0123);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Switch right after reset: background was cleared, so psum passes through
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h0123);
      @(posedge clk);
      #1;
      chk("post_rst switch psum", pe_psum_out, 16'h0123);
      chk("post_rst switch input", pe_input_out, 16'h0300);
      chk("post_rst ovf", {15'h0, pe_overflow_out}, 16'h0);

      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, 16'h0042);
      @(posedge clk);
      #1;
      chk("post_rst mac psum", pe_psum_out, 16'h0042);
      chk("post_rst mac switch", {15'h0, pe_switch_out}, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_fxp_param.md
# pe_fxp_param

Parametrised weight-stationary processing element for the systolic array. It computes `psum_out = input × active_weight + psum_in` in signed fixed point, and forwards input, valid, switch and weight-load signals one hop east and south. Weights are double-buffered: a background register loads while the foreground computes, and a registered switch swaps them. Data width, fractional bits and the overflow policy are configurable.

## Interface
Parameters:
- DATA_WIDTH, 16, width of input, weight and psum words (signed two's complement)
- FRAC_BITS, 8, fractional bits of every word (default Q8.8); legal range 0..DATA_WIDTH-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pe_psum_in  in  DATA_WIDTH  partial sum from north
- pe_weight_in  in  DATA_WIDTH  weight from north
- pe_accept_w_in  in  1  load pe_weight_in into the background weight register
- pe_input_in  in  DATA_WIDTH  activation from west
- pe_valid_in  in  1  pe_input_in/pe_psum_in valid this cycle
- pe_switch_in  in  1  promote background weight to active
- pe_psum_out  out  DATA_WIDTH  registered MAC result to south
- pe_weight_out  out  DATA_WIDTH  registered weight forwarded south
- pe_accept_w_out  out  1  registered pe_accept_w_in
- pe_input_out  out  DATA_WIDTH  registered activation to east
- pe_valid_out  out  1  registered pe_valid_in
- pe_switch_out  out  1  registered pe_switch_in
- pe_overflow_out  out  1  sticky overflow flag

## Operation
- Registers: weight_active and weight_inactive, both DATA_WIDTH. No latches; every register is flop-based and reset.
- Effective weight for the MAC: weight_inactive when pe_switch_in=1, otherwise weight_active.
- On a rising edge with pe_switch_in=1: weight_active <= weight_inactive (the pre-edge value).
- On a rising edge with pe_accept_w_in=1:
  - weight_inactive <= pe_weight_in
  - pe_weight_out <= pe_weight_in
- On a rising edge with pe_accept_w_in=0: pe_weight_out <= 0, and weight_inactive holds its value.
- Switch and accept in the same cycle:
  - The active register takes the old background value.
  - The background register takes the new pe_weight_in.
- Arithmetic:
  - Full product = pe_input_in × effective weight, 2·DATA_WIDTH bits, signed.
  - Scaled product = full product arithmetically shifted right by FRAC_BITS (truncation toward −∞).
  - Sum = scaled product + sign-extended pe_psum_in, computed at 2·DATA_WIDTH+1 bits.
  - Result = Sum reduced to DATA_WIDTH, following the overflow policy under Configuration.
- Valid path:
  - pe_valid_in=1: pe_psum_out <= result and pe_input_out <= pe_input_in.
  - pe_valid_in=0: pe_psum_out <= 0, and pe_input_out holds its value.
- Control forwarding: pe_valid_out, pe_switch_out and pe_accept_w_out always register their inputs unconditionally.
- Overflow:
  - Overflow is asserted when Sum lies outside the DATA_WIDTH signed range.
  - It is evaluated only on valid cycles.
  - pe_overflow_out is set on the edge after the first overflow and holds until rst.

## Timing
- Latency from every input to its corresponding output is one cycle. There is no stall or backpressure.
- Reset value of every output is 0, as is the reset value of both weight registers.
- Asserting rst mid-operation immediately zeroes all outputs and weights and discards any pending load or switch.
- The first edge after rst deasserts behaves as the first cycle of operation.
- A weight loaded on edge N is usable by a switch presented in cycle N+1 or later. A switch in the same cycle as the load promotes the old background value.
- Throughput is one MAC per cycle.

## Configuration
- PE_SATURATE_EN defined:
  - Out-of-range results clamp to +(2^(DATA_WIDTH−1)−1) or −2^(DATA_WIDTH−1).
  - pe_overflow_out operates as described under Operation.
- PE_SATURATE_EN undefined:
  - The result is the low DATA_WIDTH bits of Sum (wrap-around).
  - pe_overflow_out is tied to 0 and the sticky flop is removed.

## Test plan
All values are Q8.8 with default parameters.
1. Basic MAC:
   - Load 0x0200 (accept for 1 cycle), then switch.
   - Next cycle: input 0x0180, psum_in 0x0100, valid=1.
   - Required: pe_psum_out=0x0400 and pe_input_out=0x0180 one cycle later.
2. Double buffering under load:
   - Active weight is 0x0100. Load 0x0300 while valid inputs of 0x0100 stream.
   - Required: outputs stay 0x0100 until switch. On the switch cycle and after, outputs are 0x0300.
3. Simultaneous switch and accept:
   - Background is 0x0200; present accept with 0x0500 together with switch.
   - Required: active becomes 0x0200 and background becomes 0x0500. pe_weight_out=0x0500 next cycle, then 0x0000 after accept drops.
4. Saturation and sticky flag (PE_SATURATE_EN defined):
   - Input 0x7F00, weight 0x0200, psum 0.
   - Required: pe_psum_out=0x7FFF, and pe_overflow_out=1 persisting through later non-overflowing ops.
   - Negative case: input 0x8000, weight 0x0200 gives 0x8000.
5. Wrap-around (PE_SATURATE_EN undefined): same stimulus as scenario 4 gives pe_psum_out=0xFE00 with pe_overflow_out=0.
6. Invalid and reset:
   - valid=0 gives pe_psum_out=0 with pe_input_out unchanged.
   - Asserting rst mid-stream zeroes all outputs asynchronously. After release, a MAC with no load gives psum_in passthrough (weight 0).
